// File: rtl/acc8_seq.sv
// Multi-operand accumulate/subtract sequencer wrapped around an external 8-bit adder.
// Operands stream in over valid/ready; the folded sum and a sticky signed overflow stream out.
module acc8_seq #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          sub,
    input  logic [CW-1:0] count,
    input  logic [7:0]    init,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic [7:0]    add_a,
    output logic [7:0]    add_b,
    output logic          add_cin,
    input  logic [7:0]    add_sum,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_sum,
    output logic          out_ovf,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e        state_q;
    logic [7:0]    acc_q;
    logic [CW-1:0] rem_q;
    logic          sub_q;
    logic          ovf_q;
    logic          step_ovf;

    // Subtraction is A + ~B + 1, so the adder always sees an addition.
    assign add_a   = acc_q;
    assign add_b   = sub_q ? ~in_data : in_data;
    assign add_cin = sub_q;

    // Signed overflow of the addition the adder is actually performing.
    assign step_ovf = (add_a[7] == add_b[7]) & (add_sum[7] != add_a[7]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= 8'h00;
            rem_q   <= '0;
            sub_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= init;
                        sub_q   <= sub;
                        ovf_q   <= 1'b0;
                        rem_q   <= count;
                        state_q <= (count != '0) ? StAccum : StDone;
                    end
                end
                StAccum: begin
                    if (in_valid) begin
                        acc_q <= add_sum;
                        rem_q <= rem_q - CW'(1);
                        ovf_q <= ovf_q | step_ovf;
                        if (rem_q == CW'(1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_acc8_seq.sv
// Scoreboard bench for acc8_seq: bursts push expected results, a negedge monitor pops on
// each output handshake. A behavioural adder closes the add_* loop.
module tb_acc8_seq;

    logic       clk;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [3:0] count = '0;
    logic [7:0] init = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic       busy;

    acc8_seq #(.CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .count     (count),
        .init      (init),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    assign add_sum = add_a + add_b + {7'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] sum;
        logic       ovf;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int k_edge;
    int lat;
    logic [7:0] op_mem[8];
    int gap_mem[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected result", 32'(out_sum), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_sum", 32'(out_sum), 32'(e.sum));
                check("out_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    // Called at #1 after an edge while IDLE; returns #1 after the start edge.
    task automatic start_burst(input logic [7:0] i, input logic [3:0] n, input logic s,
                               input logic [7:0] esum, input logic eovf);
        exp_t e;
        e.sum = esum;
        e.ovf = eovf;
        exp_q.push_back(e);
        start = 1'b1;
        init  = i;
        count = n;
        sub   = s;
        @(posedge clk);
        #1;
        k_edge = cyc;
        start  = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] d, input int gaps);
        int t;
        repeat (gaps) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) check("in_ready timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!out_valid) check("out_valid timeout", 32'(out_valid), 32'd1);
        lat = cyc - k_edge;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_burst(input string name, input logic [7:0] i, input logic [3:0] n,
                             input logic s, input logic [7:0] esum, input logic eovf,
                             input int elat);
        start_burst(i, n, s, esum, eovf);
        for (int j = 0; j < int'(n); j++) send_op(op_mem[j], gap_mem[j]);
        wait_out();
        if (elat >= 0) check({name, " latency"}, 32'(lat), 32'(elat));
        handshake();
    endtask

    initial begin
        // Reset with random inputs
        rst_n = 1'b0;
        repeat (2) begin
            start     = 1'($urandom);
            sub       = 1'($urandom);
            count     = 4'($urandom);
            init      = 8'($urandom);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst add_a", 32'(add_a), 32'h00);
        check("rst add_cin", 32'(add_cin), 32'd0);
        check("rst out_sum", 32'(out_sum), 32'h00);
        check("rst out_ovf", 32'(out_ovf), 32'd0);
        check("rst add_b", 32'(add_b), 32'(in_data));
        start = 0; sub = 0; count = 0; init = 0; in_valid = 0; in_data = 0; out_ready = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Add burst, no stalls
        op_mem  = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        gap_mem = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_burst("add", 8'h10, 4'd3, 1'b0, 8'h16, 1'b0, 3);

        // Subtract burst, issued in the first IDLE cycle after the handshake
        start_burst(8'h05, 4'd2, 1'b1, 8'hFE, 1'b0);
        in_data = 8'h03;
        #1;
        check("sub add_b", 32'(add_b), 32'hFC);
        check("sub add_cin", 32'(add_cin), 32'd1);
        send_op(8'h03, 0);
        send_op(8'h04, 0);
        wait_out();
        check("sub latency", 32'(lat), 32'd2);
        handshake();

        // Signed overflow, sticky through a second operand
        op_mem  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst("ovf", 8'h7F, 4'd2, 1'b0, 8'h80, 1'b1, 2);
        // Unsigned wrap without signed overflow
        run_burst("wrap", 8'hFF, 4'd1, 1'b0, 8'h00, 1'b0, 1);

        // Same add burst with in_valid gaps
        op_mem  = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        gap_mem = '{2, 0, 3, 0, 0, 0, 0, 0};
        run_burst("gaps", 8'h10, 4'd3, 1'b0, 8'h16, 1'b0, 8);
        gap_mem = '{0, 0, 0, 0, 0, 0, 0, 0};

        // Output backpressure; start pulses in ACCUM and DONE must be ignored
        start_burst(8'h80, 4'd2, 1'b1, 8'h6F, 1'b1);
        send_op(8'h01, 0);
        start = 1'b1; init = 8'h00; count = 4'd0; sub = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_op(8'h10, 0);
        wait_out();
        start = 1'b1; init = 8'h33; count = 4'd0;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall out_sum", 32'(out_sum), 32'h6F);
        end
        handshake();
        check("post busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("no phantom burst", 32'(busy), 32'd0);

        // Zero-length burst
        run_burst("zero", 8'h5A, 4'd0, 1'b0, 8'h5A, 1'b0, 0);

        // Mid-burst reset discards the burst (nothing pushed for it)
        start = 1'b1; init = 8'h11; count = 4'd4; sub = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_op(8'h01, 0);
        send_op(8'h02, 0);
        check("mid in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst in_ready", 32'(in_ready), 32'd0);
        check("mrst busy", 32'(busy), 32'd0);
        check("mrst out_valid", 32'(out_valid), 32'd0);
        check("mrst out_sum", 32'(out_sum), 32'h00);
        check("mrst add_cin", 32'(add_cin), 32'd0);
        check("mrst out_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op_mem = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst("after rst", 8'h00, 4'd1, 1'b0, 8'h07, 1'b0, 1);

        repeat (2) @(posedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
